fmap_pingpong_buffer: RTL and testbench



---
 rtl/fmap_buf_pkg.sv | 23 ++
 rtl/fmap_bank.sv | 30 +++
 rtl/fmap_pingpong_buffer.sv | 132 +++++++++++++
 tb/tb_fmap_pingpong_buffer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fmap_buf_pkg.sv
// Shared types and defaults for the feature-map ping-pong buffer.
package fmap_buf_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2,
    READING = 2'd3
  } bank_state_t;

  localparam int DATA_WIDTH_DEF    = 16;
  localparam int FMAP_WIDTH_DEF    = 62;
  localparam int FMAP_HEIGHT_DEF   = 62;
  localparam int FMAP_CHANNELS_DEF = 30;
  localparam int DEPTH_DEF         = FMAP_WIDTH_DEF * FMAP_HEIGHT_DEF * FMAP_CHANNELS_DEF;
  localparam int ADDR_W_DEF        = $clog2(DEPTH_DEF);

  // A bank holds a complete frame (readable, not writable).
  function automatic logic holds_frame(bank_state_t s);
    return (s == FULL) || (s == READING);
  endfunction

endpackage

// File: rtl/fmap_bank.sv
// One feature-map bank: single write port, registered read port (1-cycle latency).
module fmap_bank
  import fmap_buf_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port; callers only strobe in-range addresses.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read; output holds when not enabled.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fmap_pingpong_buffer.sv
// Double-buffered feature-map store between two conv layers.
//
// Handshake: the write side has no back-pressure; wr_ready only advertises
// that bank[wr_bank] is EMPTY or FILLING, and a wr_valid/wr_frame_done seen
// while it is low is dropped and flagged in wr_overflow. The read side is an
// address-driven fetch: rd_en with rd_addr in cycle N yields rd_valid (and
// rd_data) in cycle N+1 only if a full bank was available in cycle N;
// otherwise rd_valid stays low (stall) and rd_data holds.
module fmap_pingpong_buffer
  import fmap_buf_pkg::*;
#(
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int FMAP_WIDTH    = FMAP_WIDTH_DEF,
  parameter int FMAP_HEIGHT   = FMAP_HEIGHT_DEF,
  parameter int FMAP_CHANNELS = FMAP_CHANNELS_DEF,
  parameter int DEPTH         = FMAP_WIDTH * FMAP_HEIGHT * FMAP_CHANNELS,
  parameter int ADDR_W        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic                  wr_valid,
  input  logic                  wr_frame_done,
  output logic                  wr_ready,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_frame_done,
  output logic                  frame_ready,
  output logic [1:0]            occupancy,
  output logic                  wr_overflow,
  output logic                  addr_err,
  output logic [5:0]            dbg_state
);

  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  bank_state_t           bank_st [2];
  bank_state_t           nst     [2];
  logic                  wr_bank, rd_bank, n_wr_bank, n_rd_bank;
  logic                  wr_ok, rd_ok, wr_in_range, rd_in_range;
  logic                  wr_we, rd_fire, rd_mem_en;
  logic                  rd_sel_q, rd_oor_q;
  logic [DATA_WIDTH-1:0] rd_hold;
  logic [DATA_WIDTH-1:0] bank_rdata [2];
  logic [1:0]            occ_next;

  assign wr_in_range = {1'b0, wr_addr} < DEPTH_LIM;
  assign rd_in_range = {1'b0, rd_addr} < DEPTH_LIM;
  assign wr_ok       = !holds_frame(bank_st[wr_bank]);
  assign rd_ok       = holds_frame(bank_st[rd_bank]);
  assign wr_we       = wr_valid && wr_ok && wr_in_range;
  assign rd_fire     = rd_en && rd_ok;
  assign rd_mem_en   = rd_fire && rd_in_range;
  assign wr_ready    = wr_ok;
  assign dbg_state   = {rd_bank, wr_bank, bank_st[1], bank_st[0]};

  // Next bank states; read-release is applied last so it wins on a shared bank.
  always_comb begin
    nst[0]    = bank_st[0];
    nst[1]    = bank_st[1];
    n_wr_bank = wr_bank;
    n_rd_bank = rd_bank;
    if (wr_we) nst[wr_bank] = FILLING;
    if (rd_fire) nst[rd_bank] = READING;
    if (wr_frame_done && wr_ok) begin
      nst[wr_bank] = FULL;
      n_wr_bank    = !wr_bank;
    end
    if (rd_frame_done && rd_ok) begin
      nst[rd_bank] = EMPTY;
      n_rd_bank    = !rd_bank;
    end
    occ_next = {1'b0, holds_frame(nst[0])} + {1'b0, holds_frame(nst[1])};
  end

  // Returned word: bank output after a good read, zero after an out-of-range read, else held.
  always_comb begin
    rd_data = rd_hold;
    if (rd_valid) rd_data = rd_oor_q ? '0 : bank_rdata[rd_sel_q];
  end

  // Bank state, pointers, registered status and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      bank_st[0]  <= EMPTY;
      bank_st[1]  <= EMPTY;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      occupancy   <= 2'd0;
      frame_ready <= 1'b0;
      rd_valid    <= 1'b0;
      rd_sel_q    <= 1'b0;
      rd_oor_q    <= 1'b0;
      rd_hold     <= '0;
      wr_overflow <= 1'b0;
      addr_err    <= 1'b0;
    end else begin
      bank_st[0]  <= nst[0];
      bank_st[1]  <= nst[1];
      wr_bank     <= n_wr_bank;
      rd_bank     <= n_rd_bank;
      occupancy   <= occ_next;
      frame_ready <= holds_frame(nst[n_rd_bank]);
      rd_valid    <= rd_fire;
      rd_sel_q    <= rd_bank;
      rd_oor_q    <= !rd_in_range;
      rd_hold     <= rd_data;
      if ((wr_valid || wr_frame_done) && !wr_ok) wr_overflow <= 1'b1;
      if ((wr_valid && !wr_in_range) || (rd_en && !rd_in_range)) addr_err <= 1'b1;
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_bank
    fmap_bank #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (DEPTH),
      .ADDR_W    (ADDR_W)
    ) u_bank (
      .clk  (clk),
      .we   (wr_we && (wr_bank == 1'(i))),
      .waddr(wr_addr),
      .wdata(wr_data),
      .re   (rd_mem_en && (rd_bank == 1'(i))),
      .raddr(rd_addr),
      .rdata(bank_rdata[i])
    );
  end

endmodule

// File: tb/tb_fmap_pingpong_buffer.sv
// Directed bench for fmap_pingpong_buffer: a vector table plus a pipelined-read sequence.
module tb_fmap_pingpong_buffer;

  localparam int DW    = 16;
  localparam int DEPTH = 62 * 62 * 30;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] wr_addr;
  logic          wr_valid, wr_frame_done, wr_ready;
  logic          rd_en, rd_valid, rd_frame_done, frame_ready;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [1:0]    occupancy;
  logic          wr_overflow, addr_err;
  logic [5:0]    dbg_state;

  fmap_pingpong_buffer dut (
    .clk          (clk),
    .reset        (reset),
    .wr_data      (wr_data),
    .wr_addr      (wr_addr),
    .wr_valid     (wr_valid),
    .wr_frame_done(wr_frame_done),
    .wr_ready     (wr_ready),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .rd_frame_done(rd_frame_done),
    .frame_ready  (frame_ready),
    .occupancy    (occupancy),
    .wr_overflow  (wr_overflow),
    .addr_err     (addr_err),
    .dbg_state    (dbg_state)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Vector record: inputs for one cycle and outputs expected just after that edge.
  // dbg = {rd_bank, wr_bank, state1, state0}; states E=0 F=1 U(full)=2 R=3.
  typedef struct {
    logic          rst;
    logic          wv;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          wfd;
    logic          re;
    logic [AW-1:0] ra;
    logic          rfd;
    logic          e_rv;
    logic [DW-1:0] e_rd;
    logic          e_wrr;
    logic          e_fr;
    logic [1:0]    e_occ;
    logic          e_ovf;
    logic          e_aerr;
    logic [5:0]    e_dbg;
  } vec_t;

  vec_t          vecs[$];
  logic [DW-1:0] exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            row    = 0;

  task automatic add(input int rst, input int wv, input int wa, input int wd, input int wfd,
                     input int re, input int ra, input int rfd,
                     input int rv, input int rd, input int wrr, input int fr, input int occ,
                     input int ovf, input int aerr, input int dbg);
    vec_t v;
    v.rst = rst[0]; v.wv = wv[0]; v.wa = wa[AW-1:0]; v.wd = wd[DW-1:0]; v.wfd = wfd[0];
    v.re = re[0]; v.ra = ra[AW-1:0]; v.rfd = rfd[0];
    v.e_rv = rv[0]; v.e_rd = rd[DW-1:0]; v.e_wrr = wrr[0]; v.e_fr = fr[0];
    v.e_occ = occ[1:0]; v.e_ovf = ovf[0]; v.e_aerr = aerr[0]; v.e_dbg = dbg[5:0];
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h want %0h", name, row, act, exp);
    end
  endtask

  // Driver: hold inputs across one rising edge, leave outputs settled for sampling.
  task automatic drive(input vec_t v);
    reset = v.rst; wr_valid = v.wv; wr_addr = v.wa; wr_data = v.wd; wr_frame_done = v.wfd;
    rd_en = v.re; rd_addr = v.ra; rd_frame_done = v.rfd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_frame_done = 1'b0;
    rd_en = 1'b0; rd_addr = '0; rd_frame_done = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    //   rst wv wa     wd      wfd re ra     rfd  rv rd      wrr fr occ ovf aerr dbg
    add(1, 0, 0,     0,      0, 0, 0,     0,   0, 0,      1, 0, 0, 0, 0, 'h00);
    // Fill bank0 and close the frame.
    add(0, 1, 0,     'h0100, 0, 0, 0,     0,   0, 0,      1, 0, 0, 0, 0, 'h01);
    add(0, 1, 1,     'h0200, 0, 0, 0,     0,   0, 0,      1, 0, 0, 0, 0, 'h01);
    add(0, 1, 2,     'h0300, 0, 0, 0,     0,   0, 0,      1, 0, 0, 0, 0, 'h01);
    add(0, 1, 3,     'h0400, 0, 0, 0,     0,   0, 0,      1, 0, 0, 0, 0, 'h01);
    add(0, 0, 0,     0,      1, 0, 0,     0,   0, 0,      1, 1, 1, 0, 0, 'h12);
    add(0, 0, 0,     0,      0, 1, 2,     0,   1, 'h0300, 1, 1, 1, 0, 0, 'h13);
    // Ping-pong overlap: fill bank1 while bank0 is read.
    add(0, 1, 5,     'hABCD, 0, 1, 0,     0,   1, 'h0100, 1, 1, 1, 0, 0, 'h17);
    add(0, 0, 0,     0,      1, 0, 0,     0,   0, 'h0100, 0, 1, 2, 0, 0, 'h0B);
    add(0, 0, 0,     0,      0, 0, 0,     1,   0, 'h0100, 1, 1, 1, 0, 0, 'h28);
    add(0, 0, 0,     0,      0, 1, 5,     0,   1, 'hABCD, 1, 1, 1, 0, 0, 'h2C);
    // Overflow with no writable bank.
    add(0, 1, 0,     'h0A0A, 0, 0, 0,     0,   0, 'hABCD, 1, 1, 1, 0, 0, 'h2D);
    add(0, 0, 0,     0,      1, 0, 0,     0,   0, 'hABCD, 0, 1, 2, 0, 0, 'h3E);
    add(0, 1, 0,     'h1111, 0, 0, 0,     0,   0, 'hABCD, 0, 1, 2, 1, 0, 'h3E);
    add(0, 0, 0,     0,      0, 0, 0,     1,   0, 'hABCD, 1, 1, 1, 1, 0, 'h12);
    add(0, 0, 0,     0,      0, 1, 0,     0,   1, 'h0A0A, 1, 1, 1, 1, 0, 'h13);
    add(0, 0, 0,     0,      0, 1, 1,     0,   1, 'h0200, 1, 1, 1, 1, 0, 'h13);
    add(0, 0, 0,     0,      0, 0, 0,     1,   0, 'h0200, 1, 0, 0, 1, 0, 'h30);
    // Read stall with no full bank: rd_valid low, rd_data held.
    for (int i = 0; i < 10; i++)
      add(0, 0, 0,   0,      0, 1, 0,     0,   0, 'h0200, 1, 0, 0, 1, 0, 'h30);
    add(0, 1, 7,     'h7777, 0, 1, 7,     0,   0, 'h0200, 1, 0, 0, 1, 0, 'h34);
    add(0, 0, 0,     0,      1, 1, 7,     0,   0, 'h0200, 1, 1, 1, 1, 0, 'h28);
    add(0, 0, 0,     0,      0, 1, 7,     0,   1, 'h7777, 1, 1, 1, 1, 0, 'h2C);
    // Simultaneous frame-done on both sides.
    add(0, 1, 9,     'h0909, 0, 0, 0,     0,   0, 'h7777, 1, 1, 1, 1, 0, 'h2D);
    add(0, 0, 0,     0,      1, 0, 0,     1,   0, 'h7777, 1, 1, 1, 1, 0, 'h12);
    add(0, 0, 0,     0,      0, 1, 9,     0,   1, 'h0909, 1, 1, 1, 1, 0, 'h13);
    // Out-of-range read, then reset while bank1 is filling.
    add(0, 0, 0,     0,      0, 1, DEPTH, 0,   1, 0,      1, 1, 1, 1, 1, 'h13);
    add(0, 1, 3,     'h3333, 0, 0, 0,     0,   0, 0,      1, 1, 1, 1, 1, 'h17);
    add(1, 0, 0,     0,      0, 0, 0,     0,   0, 0,      1, 0, 0, 0, 0, 'h00);

    for (int i = 0; i < vecs.size(); i++) begin
      row = i;
      drive(vecs[i]);
      check("rd_valid",    32'(rd_valid),    32'(vecs[i].e_rv));
      check("rd_data",     32'(rd_data),     32'(vecs[i].e_rd));
      check("wr_ready",    32'(wr_ready),    32'(vecs[i].e_wrr));
      check("frame_ready", 32'(frame_ready), 32'(vecs[i].e_fr));
      check("occupancy",   32'(occupancy),   32'(vecs[i].e_occ));
      check("wr_overflow", 32'(wr_overflow), 32'(vecs[i].e_ovf));
      check("addr_err",    32'(addr_err),    32'(vecs[i].e_aerr));
      check("dbg_state",   32'(dbg_state),   32'(vecs[i].e_dbg));
    end

    // Hand sequence: fresh frame of random words, then back-to-back reads one per cycle.
    row = 1000;
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1;
      wr_addr  = AW'(20 + i);
      wr_data  = DW'($urandom_range(0, 65535));
      exp_q.push_back(wr_data);
      step();
    end
    idle_inputs();
    wr_frame_done = 1'b1;
    step();
    idle_inputs();
    begin
      int n = 0;
      while (!frame_ready && n < 20) begin
        step();
        n++;
      end
      check("frame_ready_wait", 32'(frame_ready), 32'd1);
    end
    for (int i = 0; i < 4; i++) begin
      logic [DW-1:0] exp_word;
      row   = 1001 + i;
      rd_en = 1'b1;
      rd_addr = AW'(20 + i);
      step();
      exp_word = exp_q.pop_front();
      check("pipe_rd_valid", 32'(rd_valid), 32'd1);
      check("pipe_rd_data",  32'(rd_data),  32'(exp_word));
      if (i == 3) exp_q.push_back(exp_word);
    end
    row = 1005;
    idle_inputs();
    step();
    check("pipe_rd_idle_valid", 32'(rd_valid), 32'd0);
    check("pipe_rd_idle_hold",  32'(rd_data),  32'(exp_q.pop_front()));
    check("pipe_occupancy",     32'(occupancy), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
